// File: rtl/sequential_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per clock.
// Start/done handshake matches the sequential divider; one operation in flight.
module sequential_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 ready_o,
  output logic                 done_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH:0]     r_acc;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH:0]       w_upper;
  logic [2*WIDTH:0]     w_accNext;
  logic                 w_unused;

  // The add keeps its carry so the shift drops it into the top product bit.
  always_comb begin
    w_upper   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    w_accNext = {w_upper, r_acc[WIDTH-1:0]} >> 1;
  end

  assign w_unused = ^{r_acc[2*WIDTH], w_accNext[2*WIDTH]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mcand  <= multiplicand_i;
            r_mplier <= multiplier_i;
            r_acc    <= '0;
            r_count  <= CW'(WIDTH);
            r_state  <= S_OP;
          end
        end
        S_OP: begin
          r_acc    <= w_accNext;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_product <= w_accNext[2*WIDTH-1:0];
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o   = (r_state == S_IDLE);
  assign done_o    = (r_state == S_DONE);
  assign product_o = r_product;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Randomised bench for sequential_multiplier: cycle-level behavioural model plus
// directed literal checks (max operands, known products, ignored starts, mid-op reset).
module tb_sequential_multiplier;

  localparam int W = 32;

  logic             clk_i   = 1'b0;
  logic             reset_i = 1'b1;
  logic             start_i = 1'b0;
  logic [W-1:0]     a       = '0;
  logic [W-1:0]     b       = '0;
  logic [2*W-1:0]   product_o;
  logic             ready_o;
  logic             done_o;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  sequential_multiplier #(.WIDTH(W)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .multiplicand_i (a),
    .multiplier_i   (b),
    .product_o      (product_o),
    .ready_o        (ready_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: an accepted op is busy for W+1 edges, result appears with done W edges after acceptance.
  bit             mActive    = 1'b0;
  bit             mAcceptNow = 1'b0;
  int             edgeNo     = 0;
  int             acceptEdge = 0;
  logic [2*W-1:0] mPending   = '0;
  logic [2*W-1:0] mProduct   = '0;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mActive  = 1'b0;
      mProduct = '0;
    end else begin
      mAcceptNow = !mActive && start_i;
      edgeNo++;
      if (mActive && (edgeNo - acceptEdge) == W) mProduct = mPending;
      if (mActive && (edgeNo - acceptEdge) == W + 1) mActive = 1'b0;
      if (mAcceptNow) begin
        mActive    = 1'b1;
        acceptEdge = edgeNo;
        mPending   = (2*W)'(a) * (2*W)'(b);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (checking && !reset_i) begin
      checkOutput("ready_o", {63'b0, ready_o}, {63'b0, !mActive});
      checkOutput("done_o", {63'b0, done_o}, {63'b0, mActive && ((edgeNo - acceptEdge) == W)});
      checkOutput("product_o", product_o, mProduct);
    end
  end

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic waitReady();
    int n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("ready wait", {63'b0, ready_o}, 64'd1);
  endtask

  task automatic applyStimulus(input logic [W-1:0] aa, input logic [W-1:0] bb);
    waitReady();
    start_i = 1'b1;
    a       = aa;
    b       = bb;
    @(negedge clk_i);
    start_i = 1'b0;
    a       = W'($urandom);
    b       = W'($urandom);
  endtask

  task automatic runOp(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [2*W-1:0] lit, input bit useLit);
    int lat = 1;
    logic [2*W-1:0] expProd;
    expProd = (2*W)'(aa) * (2*W)'(bb);
    applyStimulus(aa, bb);
    while (!done_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    checkOutput("latency", 64'(lat), 64'(W + 1));
    checkOutput("product arith", product_o, expProd);
    if (useLit) checkOutput("product literal", product_o, lit);
    @(negedge clk_i);
    checkOutput("done width", {63'b0, done_o}, 64'd0);
  endtask

  initial begin
    int doneCount;
    int lat;

    repeat (2) @(negedge clk_i);
    checkOutput("reset product", product_o, 64'd0);
    checkOutput("reset ready", {63'b0, ready_o}, 64'd1);
    checkOutput("reset done", {63'b0, done_o}, 64'd0);
    #2 reset_i = 1'b0;
    @(negedge clk_i);
    checking = 1'b1;

    runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    runOp(32'd1000, 32'd50_000_000, 64'h0000_000B_A43B_7400, 1'b1);
    runOp(32'd0, 32'h1234_5678, 64'd0, 1'b1);

    // Starts during OP and DONE must be ignored.
    applyStimulus(32'h0001_0000, 32'h0001_0000);
    doneCount = 0;
    lat       = 1;
    while (lat < W + 10) begin
      if (done_o) begin
        doneCount++;
        checkOutput("ignored-start product", product_o, 64'h0000_0001_0000_0000);
      end
      if (lat == 10 || (done_o && doneCount == 1)) begin
        start_i = 1'b1;
        a       = W'($urandom);
        b       = W'($urandom);
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    start_i = 1'b0;
    checkOutput("ignored-start done count", 64'(doneCount), 64'd1);

    // Reset in the middle of an operation.
    applyStimulus(pickOperand(), pickOperand());
    repeat (16) @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    checkOutput("midreset product", product_o, 64'd0);
    checkOutput("midreset ready", {63'b0, ready_o}, 64'd1);
    checkOutput("midreset done", {63'b0, done_o}, 64'd0);
    @(negedge clk_i);
    #2 reset_i = 1'b0;
    @(negedge clk_i);
    runOp(32'd7, 32'd6, 64'd42, 1'b1);

    // start_i held high with operands changing every cycle.
    waitReady();
    start_i   = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 8 * (W + 2); i++) begin
      a = pickOperand();
      b = pickOperand();
      @(negedge clk_i);
      if (done_o) doneCount++;
    end
    start_i = 1'b0;
    checkOutput("back-to-back done count", 64'(doneCount), 64'd8);

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
      runOp(pickOperand(), pickOperand(), 64'd0, 1'b0);
    end

    repeat (4) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
